// File: rtl/regfile_wport_ctrl.sv
// Write-port sequencer for the 32x32 register file: zero-fills registers 1..REG_NUM-1
// after reset, then round-robin arbitrates two writeback requesters onto the port.
module regfile_wport_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              init_busy
);

    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic {PRIO_A, PRIO_B} prio_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

    state_t            state, state_next;
    prio_t             prio, prio_next;
    logic [ADDR_W-1:0] clr_idx, clr_idx_next;
    logic              we_next;
    logic [ADDR_W-1:0] waddr_next;
    logic [DATA_W-1:0] wdata_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            prio    <= PRIO_A;
            clr_idx <= ADDR_W'(1);
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            state   <= state_next;
            prio    <= prio_next;
            clr_idx <= clr_idx_next;
            we      <= we_next;
            waddr   <= waddr_next;
            wdata   <= wdata_next;
        end
    end

    // clr_idx parks on the last register instead of wrapping when CLEAR ends.
    always_comb begin
        state_next   = state;
        prio_next    = prio;
        clr_idx_next = clr_idx;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        init_busy    = 1'b0;
        we_next      = 1'b0;
        waddr_next   = '0;
        wdata_next   = '0;
        case (state)
            CLEAR: begin
                init_busy  = 1'b1;
                we_next    = 1'b1;
                waddr_next = clr_idx;
                if (clr_idx == LAST_IDX) begin
                    state_next = RUN;
                end else begin
                    clr_idx_next = clr_idx + ADDR_W'(1);
                end
            end
            RUN: begin
                if (a_valid && (!b_valid || prio == PRIO_A)) begin
                    a_ready   = 1'b1;
                    prio_next = PRIO_B;
                    if (a_addr != '0) begin
                        we_next    = 1'b1;
                        waddr_next = a_addr;
                        wdata_next = a_data;
                    end
                end else if (b_valid) begin
                    b_ready   = 1'b1;
                    prio_next = PRIO_A;
                    if (b_addr != '0) begin
                        we_next    = 1'b1;
                        waddr_next = b_addr;
                        wdata_next = b_data;
                    end
                end
            end
            default: state_next = CLEAR;
        endcase
    end

endmodule

// File: tb/tb_regfile_wport_ctrl.sv
// Randomized self-checking bench for regfile_wport_ctrl against a cycle-level
// behavioural model of the clear sequence and round-robin write-port arbitration.
module tb_regfile_wport_ctrl;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_valid = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              a_ready;
    logic              b_valid = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              init_busy;

    regfile_wport_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: number of clear writes already issued, and whose turn it is under contention.
    int m_cleared;
    bit m_turn_b;

    task automatic model_reset();
        m_cleared = 0;
        m_turn_b  = 1'b0;
    endtask

    // Enter at a negedge; drive inputs, check ready/init_busy, then check the port after the edge.
    task automatic do_cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                            input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                            output bit ga, output bit gb);
        bit busy, e_we, full_chk;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        busy = (m_cleared < REG_NUM - 1);
        ga = !busy && av && (!bv || !m_turn_b);
        gb = !busy && bv && !ga;
        vectors++;
        if (init_busy !== busy) begin
            miscompares++;
            $display("[TB] FAIL init_busy: got %b expected %b", init_busy, busy);
        end
        vectors++;
        if (a_ready !== ga || b_ready !== gb) begin
            miscompares++;
            $display("[TB] FAIL ready: got a=%b b=%b expected a=%b b=%b", a_ready, b_ready, ga, gb);
        end
        full_chk = 1'b1;
        e_we = 1'b0; e_addr = '0; e_data = '0;
        if (busy) begin
            m_cleared++;
            e_we = 1'b1; e_addr = ADDR_W'(m_cleared);
        end else if (ga || gb) begin
            e_addr = ga ? aa : ba;
            e_data = ga ? ad : bd;
            e_we = (e_addr != 0);
            full_chk = e_we;
            m_turn_b = ga;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (we !== e_we || (full_chk && (waddr !== e_addr || wdata !== e_data))) begin
            miscompares++;
            $display("[TB] FAIL port: got we=%b waddr=%0d wdata=%h expected we=%b waddr=%0d wdata=%h",
                     we, waddr, wdata, e_we, e_addr, e_data);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit ga, gb;
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, 1'b0, '0, '0, ga, gb);
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (we !== 1'b0 || waddr !== '0 || wdata !== '0 || init_busy !== 1'b1 ||
            a_ready !== 1'b0 || b_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s: got we=%b waddr=%0d wdata=%h busy=%b ar=%b br=%b expected 0,0,0,1,0,0",
                     tag, we, waddr, wdata, init_busy, a_ready, b_ready);
        end
    endtask

    // Enter at a negedge with rst asserted for two cycles, leave at a negedge with rst released.
    task automatic apply_reset(input logic av, input logic bv);
        a_valid = av; a_addr = 5'd7; a_data = 32'h1234_5678;
        b_valid = bv; b_addr = 5'd9; b_data = 32'h9abc_def0;
        rst = 1'b1;
        #1;
        check_reset_values("reset_values");
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset_held");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset(1'b1, 1'b1);
        idle(REG_NUM - 1);
        idle(3);
    endtask

    task automatic test_single_write();
        bit ga, gb;
        do_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, ga, gb);
        idle(2);
    endtask

    task automatic test_contention();
        bit ga, gb, pa, pb;
        int first_a;
        apply_reset(1'b0, 1'b0);
        pa = 1'b1; pb = 1'b1; first_a = -1;
        for (int i = 0; i < 40 && (pa || pb); i++) begin
            do_cycle(pa, 5'd3, 32'h11, pb, 5'd4, 32'h22, ga, gb);
            if (first_a < 0 && (ga || gb)) first_a = ga ? 1 : 0;
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        vectors++;
        if (first_a !== 1 || pa || pb) begin
            miscompares++;
            $display("[TB] FAIL contention_order: got first_a=%0d pending a=%b b=%b expected 1,0,0",
                     first_a, pa, pb);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        bit ga, gb, last_a;
        logic [ADDR_W-1:0] aa, ba;
        logic [DATA_W-1:0] ad, bd;
        aa = ADDR_W'($urandom_range(1, REG_NUM - 1)); ad = $urandom;
        ba = ADDR_W'($urandom_range(1, REG_NUM - 1)); bd = $urandom;
        last_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'b1, aa, ad, 1'b1, ba, bd, ga, gb);
            vectors++;
            if (a_ready === b_ready || (i > 0 && a_ready === last_a)) begin
                miscompares++;
                $display("[TB] FAIL alternation: cycle %0d got a_ready=%b b_ready=%b prev_a=%b",
                         i, a_ready, b_ready, last_a);
            end
            last_a = a_ready;
            if (ga) begin aa = ADDR_W'($urandom_range(1, REG_NUM - 1)); ad = $urandom; end
            if (gb) begin ba = ADDR_W'($urandom_range(1, REG_NUM - 1)); bd = $urandom; end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        idle(1);
    endtask

    task automatic test_reg0_discard();
        bit ga, gb;
        do_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, ga, gb);
        do_cycle(1'b1, 5'd0, 32'h5555_AAAA, 1'b0, '0, '0, ga, gb);
        idle(1);
    endtask

    task automatic test_random();
        bit ga, gb, pa, pb;
        logic [ADDR_W-1:0] aa, ba;
        logic [DATA_W-1:0] ad, bd;
        pa = 1'b0; pb = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
        for (int i = 0; i < 200; i++) begin
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa = 1'b1; aa = ADDR_W'($urandom); ad = $urandom;
            end
            if (!pb && ($urandom_range(0, 2) != 0)) begin
                pb = 1'b1; ba = ADDR_W'($urandom); bd = $urandom;
            end
            do_cycle(pa, aa, ad, pb, ba, bd, ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
        a_valid = 1'b0; b_valid = 1'b0;
        idle(1);
    endtask

    task automatic test_reset_mid_clear();
        apply_reset(1'b0, 1'b0);
        idle(10);
        vectors++;
        if (waddr !== 5'd10 || we !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_clear_pos: got we=%b waddr=%0d expected 1,10", we, waddr);
        end
        apply_reset(1'b0, 1'b0);
        idle(REG_NUM - 1);
        test_single_write();
    endtask

    task automatic test_reset_mid_run();
        bit ga, gb;
        do_cycle(1'b1, 5'd12, 32'hCAFE_F00D, 1'b0, '0, '0, ga, gb);
        apply_reset(1'b1, 1'b0);
        idle(REG_NUM - 1);
        idle(1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_reg0_discard();
        test_random();
        test_reset_mid_clear();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
